// File: rtl/uart_rx_core_if.sv
// Byte hand-off from the UART receive engine to its consumer (RX FIFO / register block).
// The master drives rx_data/rx_valid; the slave answers with rx_ready.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampling, mid-bit majority vote, LSB-first deframing, valid/ready output.
// Optional parity slot and check are compiled in with `define UART_RX_PARITY_EN.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int DIV_W      = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_sync,
    input  logic [DIV_W-1:0]   baud_div,
    uart_rx_core_if.master     rx_if,
    output logic               busy,
    output logic               frame_err,
    output logic               parity_err,
    output logic               overrun_err
);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    generate
        if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
            $error("uart_rx_core: DATA_BITS must be 5..8 and PARITY_ODD 0 or 1");
        end
    endgenerate

    state_t               state_reg;
    logic [DIV_W-1:0]     tick_cnt_reg;
    logic [3:0]           os_reg;
    logic [IDX_W-1:0]     bit_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [1:0]           samp_reg;
    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 rx_valid_reg;
    logic                 busy_reg;
    logic                 frame_err_reg;
    logic                 overrun_err_reg;

    logic [DIV_W-1:0]     div_m1;
    logic                 tick;
    logic                 bit_val;
    logic                 parity_bad;

    // A divisor of 0 behaves as 1; >= keeps the counter bounded if the divisor shrinks
    assign div_m1  = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
    assign tick    = (tick_cnt_reg >= div_m1);
    assign bit_val = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_sync) | (samp_reg[1] & rx_sync);

`ifdef UART_RX_PARITY_EN
    localparam logic ODD_SENSE = (PARITY_ODD != 0);
    logic parity_bad_reg;
    logic parity_err_reg;
    assign parity_bad = parity_bad_reg;
    assign parity_err = parity_err_reg;
`else
    assign parity_bad = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            tick_cnt_reg    <= '0;
            os_reg          <= '0;
            bit_idx_reg     <= '0;
            shift_reg       <= '0;
            samp_reg        <= '0;
            rx_data_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            frame_err_reg   <= 1'b0;
            overrun_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg  <= 1'b0;
            parity_err_reg  <= 1'b0;
`endif
        end else begin
            frame_err_reg   <= 1'b0;
            overrun_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg  <= 1'b0;
`endif
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + DIV_W'(1);

            if (rx_valid_reg && rx_if.rx_ready) begin
                rx_valid_reg <= 1'b0;
            end

            if (tick) begin
                if (state_reg != S_IDLE) begin
                    os_reg <= os_reg + 4'd1;
                    if (os_reg == 4'd7) samp_reg[0] <= rx_sync;
                    if (os_reg == 4'd8) samp_reg[1] <= rx_sync;
                end

                case (state_reg)
                    S_IDLE: begin
                        if (!rx_sync) begin
                            state_reg <= S_START;
                            os_reg    <= '0;
                            busy_reg  <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (os_reg == 4'd9 && bit_val) begin
                            state_reg <= S_IDLE;
                            os_reg    <= '0;
                            busy_reg  <= 1'b0;
                        end else if (os_reg == 4'd15) begin
                            state_reg   <= S_DATA;
                            bit_idx_reg <= '0;
                        end
                    end
                    S_DATA: begin
                        if (os_reg == 4'd9) begin
                            shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                        end else if (os_reg == 4'd15) begin
                            if (bit_idx_reg == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                                state_reg <= S_PARITY;
`else
                                state_reg <= S_STOP;
`endif
                            end else begin
                                bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (os_reg == 4'd9) begin
                            parity_bad_reg <= (bit_val != ((^shift_reg) ^ ODD_SENSE));
                        end else if (os_reg == 4'd15) begin
                            state_reg <= S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        // Leave at mid stop bit so the next start edge is caught early
                        if (os_reg == 4'd9) begin
                            state_reg <= S_IDLE;
                            os_reg    <= '0;
                            busy_reg  <= 1'b0;
                            if (!bit_val) begin
                                frame_err_reg <= 1'b1;
                            end else if (parity_bad) begin
`ifdef UART_RX_PARITY_EN
                                parity_err_reg <= 1'b1;
`endif
                            end else if (rx_valid_reg && !rx_if.rx_ready) begin
                                overrun_err_reg <= 1'b1;
                            end else begin
                                rx_data_reg  <= shift_reg;
                                rx_valid_reg <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        os_reg    <= '0;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_if.rx_data  = rx_data_reg;
    assign rx_if.rx_valid = rx_valid_reg;
    assign busy           = busy_reg;
    assign frame_err      = frame_err_reg;
    assign overrun_err    = overrun_err_reg;
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames are bit-banged onto rx_sync, outcomes tallied by a monitor.
// Builds with or without UART_RX_PARITY_EN; the parity slot is added to every frame when enabled.
module tb_uart_rx_core;
    localparam int DATA_BITS  = 8;
    localparam int DIV_W      = 16;
    localparam int PARITY_ODD = 0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_sync = 1'b1;
    logic [DIV_W-1:0] baud_div = 16'd4;
    logic             busy;
    logic             frame_err;
    logic             parity_err;
    logic             overrun_err;

    uart_rx_core_if #(.DATA_BITS(DATA_BITS)) rx_if ();

    uart_rx_core #(
        .DATA_BITS (DATA_BITS),
        .DIV_W     (DIV_W),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_sync    (rx_sync),
        .baud_div   (baud_div),
        .rx_if      (rx_if),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int acc_cnt = 0, valid_cyc = 0, ferr_cnt = 0, perr_cnt = 0, oerr_cnt = 0;
    int acc0, vc0, fe0, pe0, oe0;
    logic [7:0] last_data = 8'h00;
    logic       prev_valid = 1'b0;
    logic       busy_at_rise = 1'b1;
    logic       busy_mid = 1'b0;

    // Sampled mid-cycle: both the negedge-driven inputs and the post-edge outputs are settled
    always @(negedge clk) begin
        #2;
        if (rx_if.rx_valid === 1'b1) valid_cyc++;
        if (rx_if.rx_valid === 1'b1 && rx_if.rx_ready === 1'b1) begin
            acc_cnt++;
            last_data = rx_if.rx_data;
        end
        if (rx_if.rx_valid === 1'b1 && !prev_valid) busy_at_rise = busy;
        prev_valid = (rx_if.rx_valid === 1'b1);
        if (frame_err === 1'b1)   ferr_cnt++;
        if (parity_err === 1'b1)  perr_cnt++;
        if (overrun_err === 1'b1) oerr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic snap();
        acc0 = acc_cnt;
        vc0  = valid_cyc;
        fe0  = ferr_cnt;
        pe0  = perr_cnt;
        oe0  = oerr_cnt;
    endtask

    // Drives start, data (LSB first), optional parity, stop, then an idle gap.
    // rst_slot >= 0 pulses rst_n for one clock halfway through that slot.
    task automatic send_frame(input logic [7:0] data, input logic stop_val, input logic par_flip,
                              input int bit_clks, input int rst_slot, input int gap);
        logic line_v [0:10];
        int   n;
        n = 0;
        line_v[n] = 1'b0;
        n++;
        for (int i = 0; i < DATA_BITS; i++) begin
            line_v[n] = data[i];
            n++;
        end
`ifdef UART_RX_PARITY_EN
        line_v[n] = (^data) ^ (PARITY_ODD != 0) ^ par_flip;
        n++;
`else
        if (par_flip) begin end
`endif
        line_v[n] = stop_val;
        n++;
        for (int s = 0; s < n; s++) begin
            for (int c = 0; c < bit_clks; c++) begin
                @(negedge clk);
                rst_n   = 1'b1;
                rx_sync = line_v[s];
                if (s == 2 && c == 0) busy_mid = busy;
                if (s == rst_slot && c == bit_clks / 2) begin
                    rst_n = 1'b0;
                    @(posedge clk);
                    #1;
                    check("reset_mid_busy", busy, 0);
                    check("reset_mid_valid", rx_if.rx_valid, 0);
                    check("reset_mid_data", rx_if.rx_data, 0);
                end
            end
        end
        for (int c = 0; c < gap; c++) begin
            @(negedge clk);
            rst_n   = 1'b1;
            rx_sync = 1'b1;
        end
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rx_if.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_valid", rx_if.rx_valid, 0);
        check("reset_data", rx_if.rx_data, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_perr", parity_err, 0);
        check("reset_oerr", overrun_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Clean 0xA5 frame at 64 clk/bit
        snap();
        send_frame(8'hA5, 1'b1, 1'b0, 64, -1, 128);
        check("a5_busy_mid", busy_mid, 1);
        check("a5_accepted", acc_cnt - acc0, 1);
        check("a5_data", last_data, 8'hA5);
        check("a5_valid_cycles", valid_cyc - vc0, 1);
        check("a5_busy_at_valid", busy_at_rise, 0);
        check("a5_ferr", ferr_cnt - fe0, 0);
        check("a5_perr", perr_cnt - pe0, 0);
        check("a5_oerr", oerr_cnt - oe0, 0);

        // Half-bit low glitch is a false start
        snap();
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            rx_sync = 1'b0;
            if (c == 16) busy_mid = busy;
        end
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            rx_sync = 1'b1;
        end
        #1;
        check("glitch_busy_during", busy_mid, 1);
        check("glitch_busy_after", busy, 0);
        check("glitch_valid_cycles", valid_cyc - vc0, 0);
        check("glitch_ferr", ferr_cnt - fe0, 0);

        // Stop bit low: framing error, byte discarded, then a good 0x55
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 64, -1, 160);
        check("3c_ferr", ferr_cnt - fe0, 1);
        check("3c_valid_cycles", valid_cyc - vc0, 0);
        check("3c_valid", rx_if.rx_valid, 0);
        snap();
        send_frame(8'h55, 1'b1, 1'b0, 64, -1, 128);
        check("55_accepted", acc_cnt - acc0, 1);
        check("55_data", last_data, 8'h55);
        check("55_ferr", ferr_cnt - fe0, 0);

        // Consumer stalled: second byte overruns and the first is held
        rx_if.rx_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, 1'b0, 64, -1, 128);
        check("11_valid", rx_if.rx_valid, 1);
        check("11_data", rx_if.rx_data, 8'h11);
        send_frame(8'h22, 1'b1, 1'b0, 64, -1, 128);
        check("22_oerr", oerr_cnt - oe0, 1);
        check("22_held_data", rx_if.rx_data, 8'h11);
        check("22_valid", rx_if.rx_valid, 1);
        @(negedge clk);
        rx_if.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check("ready_valid_falls", rx_if.rx_valid, 0);
        check("ready_accepted", acc_cnt - acc0, 1);
        check("ready_data", last_data, 8'h11);

        // Reset during data bit 3 (slot 4); parity flip keeps the aborted tail high
        snap();
        send_frame(8'hFF, 1'b1, 1'b1, 64, 4, 160);
        check("ff_accepted", acc_cnt - acc0, 0);
        check("ff_ferr", ferr_cnt - fe0, 0);
        check("ff_busy_after", busy, 0);
        snap();
        send_frame(8'h0F, 1'b1, 1'b0, 64, -1, 128);
        check("0f_accepted", acc_cnt - acc0, 1);
        check("0f_data", last_data, 8'h0F);

        // Divisor 0 behaves as 1: 16 clk/bit
        baud_div = '0;
        repeat (4) @(negedge clk);
        snap();
        send_frame(8'h96, 1'b1, 1'b0, 16, -1, 64);
        check("96_div0_accepted", acc_cnt - acc0, 1);
        check("96_div0_data", last_data, 8'h96);
        baud_div = 16'd4;
        repeat (8) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // Even parity over 0x07 is 1: correct bit accepted, flipped bit rejected
        snap();
        send_frame(8'h07, 1'b1, 1'b0, 64, -1, 128);
        check("07_par_ok_accepted", acc_cnt - acc0, 1);
        check("07_par_ok_data", last_data, 8'h07);
        check("07_par_ok_perr", perr_cnt - pe0, 0);
        snap();
        send_frame(8'h07, 1'b1, 1'b1, 64, -1, 128);
        check("07_par_bad_perr", perr_cnt - pe0, 1);
        check("07_par_bad_valid", valid_cyc - vc0, 0);
        check("07_par_bad_ferr", ferr_cnt - fe0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
